// File: rtl/addsub_mul_pipe_p_pkg.sv
`default_nettype none
// ============================================================================
// Module   : addsub_mul_pipe_p_pkg
// Purpose  : Shared op encoding and default widths for the add/sub-multiply
//            accumulate pipeline.
// Revision : 1.0  initial release
// ============================================================================
package addsub_mul_pipe_p_pkg;

    // Default operand width and accumulator width (2*W + 8 guard bits).
    localparam int W_DEFAULT     = 8;
    localparam int ACC_W_DEFAULT = 2 * W_DEFAULT + 8;

    // Operation select encoding.
    typedef enum logic [1:0] {
        OP_SUB = 2'd0,   // c * (a - b)
        OP_ADD = 2'd1,   // c * (a + b)
        OP_MAC = 2'd2,   // acc += c * (a + b)
        OP_CLR = 2'd3    // acc  = 0
    } op_e;

endpackage : addsub_mul_pipe_p_pkg
`default_nettype wire

// File: rtl/addsub_mul_pipe_p_pipe_stage_ctl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_stage_ctl
// Purpose  : Valid/ready bookkeeping for one pipeline stage. The stage
//            advances when it is empty or its downstream consumer takes it.
// Revision : 1.0  initial release
// ============================================================================
module pipe_stage_ctl (
    input  logic clk,
    input  logic rst_n,
    input  logic up_valid_i,     // upstream offers an entry
    input  logic down_ready_i,   // downstream takes this stage's entry
    output logic advance_o,      // stage loads new contents this edge
    output logic valid_o         // stage holds a valid entry
);

    logic valid_q;
    logic valid_d;

    assign advance_o = !valid_q || down_ready_i;
    assign valid_o   = valid_q;

    // On advance the stage takes whatever upstream offers (possibly a bubble).
    always_comb begin
        valid_d = valid_q;
        if (advance_o) begin
            valid_d = up_valid_i;
        end
    end

    // Stage valid flag.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
        end
    end

endmodule : pipe_stage_ctl
`default_nettype wire

// File: rtl/addsub_mul_pipe_p.sv
`default_nettype none
// ============================================================================
// Module   : addsub_mul_pipe_p
// Purpose  : Two-stage pipeline. Stage 1 forms a-b or a+b; stage 2 multiplies
//            by c and either outputs the product, accumulates it, or clears
//            the accumulator. Full valid/ready flow control on both sides.
// Revision : 1.0  initial release
// ============================================================================
module addsub_mul_pipe_p
    import addsub_mul_pipe_p_pkg::*;
#(
    parameter int W     = W_DEFAULT,
    parameter int ACC_W = 2 * W + (ACC_W_DEFAULT - 2 * W_DEFAULT)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic [W-1:0]     c_i,
    input  logic [1:0]       op_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [ACC_W-1:0] out_data_o,
    output logic             out_valid_o,
    input  logic             out_ready_i
);

    // ------------------------------------------------------------------
    // Flow control
    // ------------------------------------------------------------------
    logic w_adv1;
    logic w_adv2;
    logic w_s1_valid;
    logic w_s2_valid;

    pipe_stage_ctl u_stage1_ctl (
        .clk          (clk),
        .rst_n        (rst_n),
        .up_valid_i   (in_valid_i),
        .down_ready_i (w_adv2),
        .advance_o    (w_adv1),
        .valid_o      (w_s1_valid)
    );

    pipe_stage_ctl u_stage2_ctl (
        .clk          (clk),
        .rst_n        (rst_n),
        .up_valid_i   (w_s1_valid),
        .down_ready_i (out_ready_i),
        .advance_o    (w_adv2),
        .valid_o      (w_s2_valid)
    );

    assign in_ready_o  = w_adv1;
    assign out_valid_o = w_s2_valid;

    // ------------------------------------------------------------------
    // Stage 1: pre-adder
    // ------------------------------------------------------------------
    logic signed [W:0]   s1_q;
    logic signed [W:0]   s1_d;
    logic [W-1:0]        c_q;
    logic [W-1:0]        c_d;
    op_e                 op_q;
    op_e                 op_d;
    logic [W:0]          w_a_ext;
    logic [W:0]          w_b_ext;

    assign w_a_ext = {1'b0, a_i};
    assign w_b_ext = {1'b0, b_i};

    // Capture operands only on an actual input transfer; bubbles leave data alone.
    always_comb begin
        s1_d = s1_q;
        c_d  = c_q;
        op_d = op_q;
        if (w_adv1 && in_valid_i) begin
            if (op_i == OP_SUB) begin
                s1_d = $signed(w_a_ext - w_b_ext);
            end else begin
                s1_d = $signed(w_a_ext + w_b_ext);
            end
            c_d  = c_i;
            op_d = op_e'(op_i);
        end
    end

    // Stage 1 data registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_q <= '0;
            c_q  <= '0;
            op_q <= OP_SUB;
        end else begin
            s1_q <= s1_d;
            c_q  <= c_d;
            op_q <= op_d;
        end
    end

    // ------------------------------------------------------------------
    // Stage 2: multiplier and accumulator
    // ------------------------------------------------------------------
    // A sum a+b can reach 2^(W+1)-2, which does not fit a W+1-bit signed
    // value, so the multiplier operand is widened by one bit: sign-extended
    // for a difference, zero-extended for a sum.
    logic signed [W+1:0]      w_mul_b;
    logic signed [W:0]        w_mul_a;
    logic signed [2*W+2:0]    w_prod;
    logic signed [ACC_W-1:0]  w_prod_ext;
    logic signed [ACC_W-1:0]  w_mac_sum;
    logic signed [ACC_W-1:0]  acc_q;
    logic signed [ACC_W-1:0]  acc_d;
    logic signed [ACC_W-1:0]  out_q;
    logic signed [ACC_W-1:0]  out_d;

    assign w_mul_b    = (op_q == OP_SUB) ? {s1_q[W], s1_q} : {1'b0, s1_q};
    assign w_mul_a    = $signed({1'b0, c_q});
    assign w_prod     = w_mul_a * w_mul_b;
    assign w_prod_ext = ACC_W'(w_prod);
    assign w_mac_sum  = acc_q + w_prod_ext;

    assign out_data_o = out_q;

    // Result/accumulator update when a valid stage-1 entry moves into stage 2.
    always_comb begin
        acc_d = acc_q;
        out_d = out_q;
        if (w_adv2 && w_s1_valid) begin
            case (op_q)
                OP_SUB, OP_ADD: begin
                    out_d = w_prod_ext;
                end
                OP_MAC: begin
                    acc_d = w_mac_sum;
                    out_d = w_mac_sum;
                end
                OP_CLR: begin
                    acc_d = '0;
                    out_d = '0;
                end
                default: begin
                    out_d = out_q;
                end
            endcase
        end
    end

    // Stage 2 result and accumulator registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            out_q <= '0;
        end else begin
            acc_q <= acc_d;
            out_q <= out_d;
        end
    end

endmodule : addsub_mul_pipe_p
`default_nettype wire

// File: tb/tb_addsub_mul_pipe_p.sv
`default_nettype none
// ============================================================================
// Module   : tb_addsub_mul_pipe_p
// Purpose  : Self-checking bench for addsub_mul_pipe_p (W=8, ACC_W=24).
// Revision : 1.0  initial release
// ============================================================================
module tb_addsub_mul_pipe_p;

    localparam int W     = 8;
    localparam int ACC_W = 24;

    logic             clk = 1'b0;
    logic             rst_n;
    logic [W-1:0]     a_i, b_i, c_i;
    logic [1:0]       op_i;
    logic             in_valid_i;
    logic             in_ready_o;
    logic [ACC_W-1:0] out_data_o;
    logic             out_valid_o;
    logic             out_ready_i;

    int total = 0;
    int bad   = 0;

    // Reference model state: accumulator and expected-result queue.
    longint           m_acc = 0;
    logic [ACC_W-1:0] exp_q[$];

    addsub_mul_pipe_p #(.W(W), .ACC_W(ACC_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .a_i         (a_i),
        .b_i         (b_i),
        .c_i         (c_i),
        .op_i        (op_i),
        .in_valid_i  (in_valid_i),
        .in_ready_o  (in_ready_o),
        .out_data_o  (out_data_o),
        .out_valid_o (out_valid_o),
        .out_ready_i (out_ready_i)
    );

    always #5 clk = ~clk;

    // Result of one operation in plain integer arithmetic, modulo 2^ACC_W.
    function automatic logic [ACC_W-1:0] model(input logic [1:0] op, input logic [W-1:0] a,
                                               input logic [W-1:0] b, input logic [W-1:0] c);
        longint la = longint'(a);
        longint lb = longint'(b);
        longint lc = longint'(c);
        longint r;
        case (op)
            2'd0:    r = lc * (la - lb);
            2'd1:    r = lc * (la + lb);
            2'd2:    begin m_acc = (m_acc + lc * (la + lb)) & 64'hFFFFFF; r = m_acc; end
            default: begin m_acc = 0; r = 0; end
        endcase
        return r[ACC_W-1:0];
    endfunction

    // One clock: called at a negedge, drives inputs, samples outputs,
    // reports transfers for the coming posedge, returns at the next negedge.
    task automatic step(input bit iv, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] c, input bit ordy,
                        output bit in_fire, output bit out_fire, output bit ov, output bit ir,
                        output logic [ACC_W-1:0] got, output bit have_exp,
                        output logic [ACC_W-1:0] exp_v);
        in_valid_i  = iv;
        op_i        = op;
        a_i         = a;
        b_i         = b;
        c_i         = c;
        out_ready_i = ordy;
        #1;
        ir       = in_ready_o;
        ov       = out_valid_o;
        got      = out_data_o;
        in_fire  = iv && ir;
        out_fire = ov && ordy;
        have_exp = 1'b0;
        exp_v    = '0;
        if (out_fire && exp_q.size() > 0) begin
            exp_v    = exp_q.pop_front();
            have_exp = 1'b1;
        end
        if (in_fire) exp_q.push_back(model(op, a, b, c));
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b1;
        a_i = '0; b_i = '0; c_i = '0; op_i = 2'd0;
        repeat (3) @(negedge clk);
        total++; if (out_valid_o !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid_o); end
        total++; if (out_data_o !== '0) begin bad++; $display("FAIL reset_out_data got=%0h want=0", out_data_o); end
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready_o); end
        rst_n = 1'b1;
        m_acc = 0; exp_q.delete();
        @(negedge clk);
    endtask

    task automatic test_sub_latency();
        bit inf, outf, ov, ir, he; logic [ACC_W-1:0] got, ev;
        step(1, 2'd0, 8'd200, 8'd55, 8'd3, 1, inf, outf, ov, ir, got, he, ev);
        total++; if (inf !== 1'b1) begin bad++; $display("FAIL sub_accept got=%0b want=1", inf); end
        step(0, 2'd0, 0, 0, 0, 1, inf, outf, ov, ir, got, he, ev);
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL sub_early_valid got=%0b want=0", ov); end
        step(0, 2'd0, 0, 0, 0, 1, inf, outf, ov, ir, got, he, ev);
        total++; if (ov !== 1'b1) begin bad++; $display("FAIL sub_latency_valid got=%0b want=1", ov); end
        total++; if (got !== 24'd435) begin bad++; $display("FAIL sub_435 got=%0d want=435", got); end
    endtask

    task automatic test_sub_add();
        logic [1:0] ops[2] = '{2'd0, 2'd1};
        logic [7:0] av[2] = '{8'd10, 8'd255};
        logic [7:0] bv[2] = '{8'd20, 8'd255};
        logic [7:0] cv[2] = '{8'd5, 8'd255};
        logic [ACC_W-1:0] want[2] = '{24'hFFFFCE, 24'd130050};
        bit inf, outf, ov, ir, he; logic [ACC_W-1:0] got, ev;
        int i = 0, n = 0;
        for (int k = 0; k < 30 && n < 2; k++) begin
            step(i < 2, (i < 2) ? ops[i] : 2'd0, (i < 2) ? av[i] : 8'd0, (i < 2) ? bv[i] : 8'd0,
                 (i < 2) ? cv[i] : 8'd0, 1, inf, outf, ov, ir, got, he, ev);
            if (inf) i++;
            if (outf) begin
                total++; if (got !== want[n]) begin bad++; $display("FAIL subadd_result[%0d] got=%0h want=%0h", n, got, want[n]); end
                n++;
            end
        end
        total++; if (n != 2) begin bad++; $display("FAIL subadd_timeout got=%0d want=2 results", n); end
    endtask

    task automatic test_mac();
        logic [1:0] ops[4] = '{2'd3, 2'd2, 2'd2, 2'd2};
        logic [7:0] av[4] = '{8'd0, 8'd1, 8'd3, 8'd0};
        logic [7:0] bv[4] = '{8'd0, 8'd2, 8'd3, 8'd0};
        logic [7:0] cv[4] = '{8'd0, 8'd4, 8'd10, 8'd7};
        logic [ACC_W-1:0] want[4] = '{24'd0, 24'd12, 24'd72, 24'd72};
        bit inf, outf, ov, ir, he; logic [ACC_W-1:0] got, ev;
        int i = 0, n = 0, stalls = 0;
        for (int k = 0; k < 30 && n < 4; k++) begin
            step(i < 4, (i < 4) ? ops[i] : 2'd0, (i < 4) ? av[i] : 8'd0, (i < 4) ? bv[i] : 8'd0,
                 (i < 4) ? cv[i] : 8'd0, 1, inf, outf, ov, ir, got, he, ev);
            if (i < 4 && !inf) stalls++;
            if (inf) i++;
            if (outf) begin
                total++; if (got !== want[n]) begin bad++; $display("FAIL mac_result[%0d] got=%0d want=%0d", n, got, want[n]); end
                n++;
            end
        end
        total++; if (n != 4) begin bad++; $display("FAIL mac_timeout got=%0d want=4 results", n); end
        total++; if (stalls != 0) begin bad++; $display("FAIL mac_bubble got=%0d want=0 input stalls", stalls); end
    endtask

    task automatic test_stall();
        logic [7:0] av[3] = '{8'd1, 8'd10, 8'd100};
        logic [7:0] bv[3] = '{8'd2, 8'd20, 8'd50};
        logic [7:0] cv[3] = '{8'd3, 8'd2, 8'd4};
        logic [ACC_W-1:0] want[3] = '{24'd9, 24'd60, 24'd600};
        bit inf, outf, ov, ir, he; logic [ACC_W-1:0] got, ev;
        int i = 0, n = 0;
        for (int k = 0; k < 30 && n < 3; k++) begin
            step(i < 3, 2'd1, (i < 3) ? av[i] : 8'd0, (i < 3) ? bv[i] : 8'd0,
                 (i < 3) ? cv[i] : 8'd0, k >= 4, inf, outf, ov, ir, got, he, ev);
            if (k == 2) begin
                total++; if (ir !== 1'b0 || i != 2) begin bad++; $display("FAIL stall_in_ready got=%0b/%0d want=0/2 accepted", ir, i); end
            end
            if (k == 2 || k == 3) begin
                total++; if (ov !== 1'b1 || got !== want[0]) begin bad++; $display("FAIL stall_hold[%0d] got=%0b/%0d want=1/%0d", k, ov, got, want[0]); end
            end
            if (inf) i++;
            if (outf) begin
                total++; if (got !== want[n]) begin bad++; $display("FAIL stall_order[%0d] got=%0d want=%0d", n, got, want[n]); end
                n++;
            end
        end
        total++; if (n != 3) begin bad++; $display("FAIL stall_timeout got=%0d want=3 results", n); end
    endtask

    task automatic test_reset_midflight();
        bit inf, outf, ov, ir, he; logic [ACC_W-1:0] got, ev;
        step(1, 2'd2, 8'd5, 8'd5, 8'd5, 1, inf, outf, ov, ir, got, he, ev);
        step(1, 2'd2, 8'd2, 8'd2, 8'd2, 1, inf, outf, ov, ir, got, he, ev);
        in_valid_i = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++; if (out_valid_o !== 1'b0 || out_data_o !== '0) begin bad++; $display("FAIL midreset_clear got=%0b/%0h want=0/0", out_valid_o, out_data_o); end
        total++; if (in_ready_o !== 1'b1) begin bad++; $display("FAIL midreset_in_ready got=%0b want=1", in_ready_o); end
        @(posedge clk); @(negedge clk);
        rst_n = 1'b1;
        m_acc = 0; exp_q.delete();
        step(1, 2'd2, 8'd1, 8'd1, 8'd1, 1, inf, outf, ov, ir, got, he, ev);
        step(0, 2'd0, 0, 0, 0, 1, inf, outf, ov, ir, got, he, ev);
        total++; if (ov !== 1'b0) begin bad++; $display("FAIL midreset_early got=%0b want=0", ov); end
        step(0, 2'd0, 0, 0, 0, 1, inf, outf, ov, ir, got, he, ev);
        total++; if (ov !== 1'b1 || got !== 24'd2) begin bad++; $display("FAIL midreset_mac got=%0b/%0d want=1/2", ov, got); end
    endtask

    task automatic test_random();
        bit inf, outf, ov, ir, he; logic [ACC_W-1:0] got, ev;
        logic [1:0] op; logic [7:0] a, b, c;
        bit prev_stall = 0; logic [ACC_W-1:0] prev_got = '0;
        int i = 0, n = 0, errs = 0;
        op = 2'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
        for (int k = 0; k < 3000 && !(i == 200 && exp_q.size() == 0); k++) begin
            step((i < 200) && ($urandom_range(0, 3) != 0), op, a, b, c, $urandom_range(0, 9) < 7,
                 inf, outf, ov, ir, got, he, ev);
            if (prev_stall && (ov !== 1'b1 || got !== prev_got)) begin
                errs++; total++; bad++;
                $display("FAIL rand_hold got=%0b/%0h want=1/%0h", ov, got, prev_got);
            end
            prev_stall = ov && !outf;
            prev_got   = got;
            if (outf) begin
                total++;
                if (!he) begin bad++; errs++; $display("FAIL rand_duplicate got=%0h want=no output", got); end
                else if (got !== ev) begin bad++; errs++; $display("FAIL rand_result[%0d] got=%0h want=%0h", n, got, ev); end
                n++;
            end
            if (inf) begin
                i++;
                op = 2'($urandom_range(0, 3)); a = 8'($urandom); b = 8'($urandom); c = 8'($urandom);
            end
        end
        total++; if (n != 200 || exp_q.size() != 0) begin bad++; $display("FAIL rand_count got=%0d results want=200 (pending %0d)", n, exp_q.size()); end
    endtask

    initial begin
        test_reset();
        test_sub_latency();
        test_sub_add();
        test_mac();
        test_stall();
        test_reset_midflight();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_addsub_mul_pipe_p
`default_nettype wire
